// File: rtl/buffer_ram_pkg.sv
// -----------------------------------------------------------------------------
// buffer_ram_pkg
// Shared definitions for the frame-buffer controller and buffer_ram_dp:
//   - default RAM address/data widths and the frame size (160x120 pixels)
//   - capture FSM state encoding
//   - test-pattern generator used when RAMCTRL_TESTPAT_EN is defined
// -----------------------------------------------------------------------------
package buffer_ram_pkg;

    localparam int RAM_AW        = 15;
    localparam int RAM_DW        = 16;
    localparam int RAM_FRAME_PIX = 19200;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // RGB565-style ramp derived from the pixel index.
    function automatic logic [15:0] test_pattern(input logic [10:0] idx);
        return {idx[4:0], idx[10:5], idx[4:0]};
    endfunction

endpackage

// File: rtl/ram_rd_seq.sv
// -----------------------------------------------------------------------------
// ram_rd_seq
// Display-side read sequencer for the frame buffer. Keeps a linear read
// pointer that wraps at the end of the frame and a two-stage valid pipe that
// matches the one-cycle read latency of buffer_ram_dp.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   rd_sof         restart the read pointer at address 0
//   rd_req         fetch next pixel
//   ram_data_out   RAM read data (valid one clock after regread is sampled)
//   ram_regread    RAM read enable
//   ram_addr_out   RAM read address
//   rd_valid       rd_data valid
//   rd_data        fetched pixel
// -----------------------------------------------------------------------------
module ram_rd_seq
    import buffer_ram_pkg::*;
#(
    parameter int AW        = RAM_AW,
    parameter int DW        = RAM_DW,
    parameter int FRAME_PIX = RAM_FRAME_PIX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_sof,
    input  logic          rd_req,
    input  logic [DW-1:0] ram_data_out,
    output logic          ram_regread,
    output logic [AW-1:0] ram_addr_out,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_PIX - 1);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_base;

    // A start-of-frame in the same cycle as a request reads address 0.
    assign rd_base = rd_sof ? '0 : rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= '0;
            ram_regread  <= 1'b0;
            ram_addr_out <= '0;
            rd_valid     <= 1'b0;
        end else begin
            ram_regread <= rd_req;
            rd_valid    <= ram_regread;
            if (rd_req) begin
                ram_addr_out <= rd_base;
                rd_ptr       <= (rd_base == LAST_ADDR) ? '0 : rd_base + 1'b1;
            end else if (rd_sof) begin
                rd_ptr <= '0;
            end
        end
    end

    // The RAM output is already registered, so the data stage is just a gate
    // that keeps rd_data at zero outside valid beats.
    assign rd_data = rd_valid ? ram_data_out : '0;

endmodule

// File: rtl/buffer_ram_ctrl.sv
// -----------------------------------------------------------------------------
// buffer_ram_ctrl
// Sequencer between camera pixel capture, display fetch and the buffer_ram_dp
// frame buffer. The write side arms on cap_en, waits for frame_start and
// writes one frame of pixels at linear addresses. The read side (ram_rd_seq)
// serves display fetches from a wrapping linear pointer. This block owns every
// buffer_ram_dp port.
// Configuration macro: RAMCTRL_TESTPAT_EN -- when defined, captured pixels are
// replaced by a ramp pattern derived from the write address.
// Ports:
//   clk, rst                      system clock, synchronous active-high reset
//   cap_en                        level: capture enabled
//   frame_start                   one-cycle pulse at camera frame start
//   pix_valid, pix_data           captured pixel strobe and data
//   frame_done                    pulse: full frame written
//   short_frame                   pulse: frame_start arrived mid-capture
//   busy                          capture in progress
//   rd_sof, rd_req                read restart / fetch request
//   rd_valid, rd_data             fetched pixel
//   ram_addr_in, ram_data_in,
//   ram_regwrite                  RAM write port
//   ram_addr_out, ram_regread     RAM read port
//   ram_data_out                  RAM read data
// -----------------------------------------------------------------------------
module buffer_ram_ctrl
    import buffer_ram_pkg::*;
#(
    parameter int AW        = RAM_AW,
    parameter int DW        = RAM_DW,
    parameter int FRAME_PIX = RAM_FRAME_PIX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap_en,
    input  logic          frame_start,
    input  logic          pix_valid,
    input  logic [DW-1:0] pix_data,
    output logic          frame_done,
    output logic          short_frame,
    output logic          busy,
    input  logic          rd_sof,
    input  logic          rd_req,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] ram_addr_in,
    output logic [DW-1:0] ram_data_in,
    output logic          ram_regwrite,
    output logic [AW-1:0] ram_addr_out,
    output logic          ram_regread,
    input  logic [DW-1:0] ram_data_out
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_PIX - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] wr_cnt, wr_cnt_nxt;
    logic          wr_en_nxt;
    logic [AW-1:0] wr_addr_nxt;
    logic [DW-1:0] wr_data_nxt;
    logic          short_nxt;

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        wr_cnt_nxt  = wr_cnt;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_cnt;
        short_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (cap_en) state_nxt = ARMED;
            end
            ARMED: begin
                if (!cap_en) begin
                    state_nxt = IDLE;
                end else if (frame_start) begin
                    state_nxt  = CAPTURE;
                    wr_cnt_nxt = '0;
                end
            end
            CAPTURE: begin
                // A new frame_start restarts the frame; a pixel in the same
                // cycle belongs to the new frame and lands at address 0.
                if (frame_start) begin
                    short_nxt   = 1'b1;
                    wr_addr_nxt = '0;
                    wr_cnt_nxt  = '0;
                end
                if (pix_valid) begin
                    wr_en_nxt = 1'b1;
                    if (wr_addr_nxt == LAST_ADDR) begin
                        wr_cnt_nxt = '0;
                        state_nxt  = DONE;
                    end else begin
                        wr_cnt_nxt = wr_addr_nxt + 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = cap_en ? ARMED : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef RAMCTRL_TESTPAT_EN
    logic [10:0] pat_idx;
    assign pat_idx     = wr_addr_nxt[10:0];
    assign wr_data_nxt = DW'(test_pattern(pat_idx));
`else
    assign wr_data_nxt = pix_data;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_cnt       <= '0;
            ram_regwrite <= 1'b0;
            ram_addr_in  <= '0;
            ram_data_in  <= '0;
            short_frame  <= 1'b0;
        end else begin
            state        <= state_nxt;
            wr_cnt       <= wr_cnt_nxt;
            ram_regwrite <= wr_en_nxt;
            short_frame  <= short_nxt;
            if (wr_en_nxt) begin
                ram_addr_in <= wr_addr_nxt;
                ram_data_in <= wr_data_nxt;
            end
        end
    end

    assign busy       = (state == CAPTURE);
    assign frame_done = (state == DONE);

    ram_rd_seq #(
        .AW        (AW),
        .DW        (DW),
        .FRAME_PIX (FRAME_PIX)
    ) u_rd_seq (
        .clk          (clk),
        .rst          (rst),
        .rd_sof       (rd_sof),
        .rd_req       (rd_req),
        .ram_data_out (ram_data_out),
        .ram_regread  (ram_regread),
        .ram_addr_out (ram_addr_out),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data)
    );

endmodule

// File: tb/tb_buffer_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_buffer_ram_ctrl
// Self-checking bench for buffer_ram_ctrl. A behavioural stand-in for
// buffer_ram_dp hangs off the RAM ports. Stimulus tasks run a frame-level
// reference model and push expected writes, reads and pulses into queues; a
// negedge monitor pops and compares whenever the DUT presents them.
// -----------------------------------------------------------------------------
module tb_buffer_ram_ctrl;

    localparam int AW        = 15;
    localparam int DW        = 16;
    localparam int FRAME_PIX = 19200;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    localparam int EV_DONE  = 1;
    localparam int EV_SHORT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cap_en, frame_start, pix_valid;
    logic [DW-1:0] pix_data;
    logic          frame_done, short_frame, busy;
    logic          rd_sof, rd_req, rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] ram_addr_in, ram_addr_out;
    logic [DW-1:0] ram_data_in, ram_data_out;
    logic          ram_regwrite, ram_regread;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    buffer_ram_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cap_en       (cap_en),
        .frame_start  (frame_start),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .frame_done   (frame_done),
        .short_frame  (short_frame),
        .busy         (busy),
        .rd_sof       (rd_sof),
        .rd_req       (rd_req),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .ram_addr_in  (ram_addr_in),
        .ram_data_in  (ram_data_in),
        .ram_regwrite (ram_regwrite),
        .ram_addr_out (ram_addr_out),
        .ram_regread  (ram_regread),
        .ram_data_out (ram_data_out)
    );

    // Behavioural dual-port RAM: registered read returning old data on a
    // same-address collision.
    logic [DW-1:0] ram_mem [2**AW];
    initial begin
        for (int i = 0; i < 2**AW; i++) ram_mem[i] = '0;
        ram_data_out = '0;
    end
    always @(posedge clk) begin
        if (ram_regwrite) ram_mem[ram_addr_in] <= ram_data_in;
        if (ram_regread)  ram_data_out <= ram_mem[ram_addr_out];
    end

    // ---------------- scoreboard queues ----------------
    wr_t           wr_q[$];
    logic [AW-1:0] rd_addr_q[$];
    logic [DW-1:0] rd_data_q[$];
    int            ev_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (ram_regwrite) begin
            if (wr_q.size() == 0) begin
                check("spurious_write", 64'(ram_addr_in), 64'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_addr", 64'(ram_addr_in), 64'(e.addr));
                check("wr_data", 64'(ram_data_in), 64'(e.data));
            end
        end
        if (ram_regread) begin
            if (rd_addr_q.size() == 0) check("spurious_read", 64'(ram_addr_out), 64'hFFFF_FFFF);
            else check("rd_addr", 64'(ram_addr_out), 64'(rd_addr_q.pop_front()));
        end
        if (rd_valid) begin
            if (rd_data_q.size() == 0) check("spurious_rd_valid", 64'(rd_data), 64'hFFFF_FFFF);
            else check("rd_data", 64'(rd_data), 64'(rd_data_q.pop_front()));
        end
        if (frame_done) begin
            if (ev_q.size() == 0) check("spurious_frame_done", 64'd1, 64'd0);
            else check("frame_done_event", 64'(ev_q.pop_front()), 64'(EV_DONE));
        end
        if (short_frame) begin
            if (ev_q.size() == 0) check("spurious_short_frame", 64'd1, 64'd0);
            else check("short_frame_event", 64'(ev_q.pop_front()), 64'(EV_SHORT));
        end
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [2**AW];
    bit            m_armed, m_capturing, m_finishing;
    int            m_idx;
    int            m_rd_ptr;

    function automatic logic [DW-1:0] model_data(input int idx, input logic [DW-1:0] pd);
`ifdef RAMCTRL_TESTPAT_EN
        logic [14:0] v;
        v = 15'(idx);
        return {v[4:0], v[10:5], v[4:0]};
`else
        return pd;
`endif
    endfunction

    // One clock of stimulus: apply inputs, advance the model, then step.
    task automatic cyc(input logic ce, input logic fs, input logic pv,
                       input logic [DW-1:0] pd, input logic sof, input logic req);
        cap_en = ce; frame_start = fs; pix_valid = pv; pix_data = pd;
        rd_sof = sof; rd_req = req;
        // Read side first: a write issued this cycle lands after this read.
        if (req) begin
            int a;
            a = sof ? 0 : m_rd_ptr;
            rd_addr_q.push_back(AW'(a));
            rd_data_q.push_back(m_mem[a]);
            m_rd_ptr = (a + 1) % FRAME_PIX;
        end else if (sof) begin
            m_rd_ptr = 0;
        end
        if (m_finishing) begin
            m_finishing = 0;
            m_armed     = ce;
        end else if (m_capturing) begin
            if (fs) begin
                ev_q.push_back(EV_SHORT);
                m_idx = 0;
            end
            if (pv) begin
                wr_t w;
                w.addr = AW'(m_idx);
                w.data = model_data(m_idx, pd);
                wr_q.push_back(w);
                m_mem[m_idx] = w.data;
                m_idx++;
                if (m_idx == FRAME_PIX) begin
                    m_idx       = 0;
                    m_capturing = 0;
                    m_finishing = 1;
                    ev_q.push_back(EV_DONE);
                end
            end
        end else if (m_armed) begin
            if (!ce) begin
                m_armed = 0;
            end else if (fs) begin
                m_armed     = 0;
                m_capturing = 1;
                m_idx       = 0;
            end
        end else if (ce) begin
            m_armed = 1;
        end
        @(posedge clk); #1;
        check("busy", 64'(busy), 64'(m_capturing));
    endtask

    task automatic check_reset_outputs();
        check("reset_ctrl", 64'({busy, frame_done, short_frame, ram_regwrite, ram_regread, rd_valid}), 64'd0);
        check("reset_addr", 64'({ram_addr_in, ram_addr_out}), 64'd0);
        check("reset_data", 64'({ram_data_in, rd_data}), 64'd0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        cap_en = 1'b1; frame_start = 1'b1; pix_valid = 1'b1; pix_data = 16'hFFFF;
        rd_sof = 1'b0; rd_req = 1'b0;
        m_armed = 0; m_capturing = 0; m_finishing = 0; m_idx = 0; m_rd_ptr = 0;
        repeat (n) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        check_reset_outputs();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
        rst = 1'b1;
        cap_en = 0; frame_start = 0; pix_valid = 0; pix_data = '0; rd_sof = 0; rd_req = 0;
        @(posedge clk); #1;
        do_reset(3);

        // Idle: pixels and frame_start are ignored without cap_en.
        for (int i = 0; i < 6; i++) cyc(0, i == 2, 1, 16'($urandom), 0, 0);

        // Armed: pixels dropped; dropping cap_en returns to idle; re-arm.
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 16'($urandom), 0, 0);
        cyc(0, 1, 1, 16'($urandom), 0, 0);
        cyc(0, 0, 1, 16'($urandom), 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 16'($urandom), 0, 0);

        // Short frame: restart after 50 pixels, restarting pixel goes to 0.
        cyc(1, 1, 1, 16'($urandom), 0, 0);
        for (int n = 0; n < 50; ) begin
            logic pv;
            pv = ($urandom_range(0, 3) != 0);
            cyc(1, 0, pv, 16'($urandom), 0, 0);
            if (pv) n++;
        end
        cyc(1, 1, 1, 16'($urandom), 0, 0);
        for (int i = 0; i < 30; i++) cyc(1, 0, ($urandom_range(0, 1) != 0), 16'($urandom), 0, 0);
        cyc(1, 1, 0, 16'($urandom), 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 16'($urandom), 0, 0);

        // Reset in the middle of a capture.
        do_reset(3);

        // Full frame with gaps, data equal to address; cap_en drops mid-frame.
        cyc(1, 0, 0, '0, 0, 0);
        cyc(1, 0, 1, '0, 0, 0);
        cyc(1, 1, 1, '0, 0, 0);
        for (int i = 0; i < 40000 && m_capturing; i++) begin
            cyc(m_idx < 10000, 0, ($urandom_range(0, 3) != 0), DW'(m_idx), 0, 0);
        end
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 16'($urandom), 0, 0);

        // Read wrap: start of frame, then 19201 requests with occasional gaps.
        cyc(0, 0, 0, '0, 1, 1);
        for (int rem = FRAME_PIX; rem > 0; ) begin
            logic r;
            r = ($urandom_range(0, 7) != 0);
            cyc(0, 0, 0, '0, 0, r);
            if (r) rem--;
        end
        // rd_sof alone restarts the pointer.
        cyc(0, 0, 0, '0, 0, 1);
        cyc(0, 0, 0, '0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0, 0, 0);

        // Concurrent same-address read and write: reads return old data.
        cyc(1, 0, 0, '0, 0, 0);
        cyc(1, 1, 0, '0, 0, 0);
        for (int i = 0; i < 40; i++) cyc(1, 0, 1, 16'($urandom), i == 0, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, '0, 0, 0);

        check("wr_queue_drained", 64'(wr_q.size()), 64'd0);
        check("rd_addr_queue_drained", 64'(rd_addr_q.size()), 64'd0);
        check("rd_data_queue_drained", 64'(rd_data_q.size()), 64'd0);
        check("event_queue_drained", 64'(ev_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
